// File: rtl/multi_datapath_if.sv
// rtl/multi_datapath_if.sv - memory-side bus between the multi-cycle datapath and its memory
interface multi_datapath_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/multi_datapath.sv
// rtl/multi_datapath.sv - multi-cycle MIPS-style datapath: PC, IR, MDR, A/B, ALUOut and register file
module multi_datapath #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_or_d,
  input  logic             ireg_enab,
  input  logic [1:0]       pc_src,
  input  logic             pc_write,
  input  logic             branch,
  input  logic             mem_to_reg,
  input  logic             reg_dst,
  input  logic             reg_write,
  input  logic             alu_srcA,
  input  logic [1:0]       alu_srcB,
  input  logic [1:0]       alu_op,
  multi_datapath_if.master mem,
  output logic [5:0]       op,
  output logic [XLEN-1:0]  pc_out
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ir;
  logic [XLEN-1:0] mdr;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] rf [NREG];

  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_sum;
  logic [XLEN-1:0] alu_diff;
  logic            alu_lt;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] pc_next;
  logic            zero;
  logic            pc_en;

  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm_sext = {{(XLEN-16){ir[15]}}, ir[15:0]};

  // Register 0 and any index beyond NREG read as zero; reads see pre-write contents.
  assign rs_data = (rs == 5'd0 || int'(rs) >= NREG) ? '0 : rf[rs];
  assign rt_data = (rt == 5'd0 || int'(rt) >= NREG) ? '0 : rf[rt];

  assign wb_addr = reg_dst ? rd : rt;
  assign wb_data = mem_to_reg ? mdr : alu_out;

  always_comb begin
    alu_a = alu_srcA ? a_reg : pc;
    case (alu_srcB)
      2'b00:   alu_b = b_reg;
      2'b01:   alu_b = XLEN'(4);
      2'b10:   alu_b = imm_sext;
      2'b11:   alu_b = {imm_sext[XLEN-3:0], 2'b00};
      default: alu_b = b_reg;
    endcase
  end

  assign alu_sum  = alu_a + alu_b;
  assign alu_diff = alu_a - alu_b;
  assign alu_lt   = $signed(alu_a) < $signed(alu_b);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      2'b00: alu_result = alu_sum;
      2'b01: alu_result = alu_diff;
      2'b10: begin
        case (ir[5:0])
          6'h20:   alu_result = alu_sum;
          6'h22:   alu_result = alu_diff;
          6'h24:   alu_result = alu_a & alu_b;
          6'h25:   alu_result = alu_a | alu_b;
          6'h2A:   alu_result[0] = alu_lt;
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    case (pc_src)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = {pc[XLEN-1:28], ir[25:0], 2'b00};
      default: pc_next = pc;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ireg_enab) begin
        ir <= mem.mem_rdata;
      end
      mdr     <= mem.mem_rdata;
      a_reg   <= rs_data;
      b_reg   <= rt_data;
      alu_out <= alu_result;
      if (pc_en) begin
        pc <= pc_next;
      end
      // Writes to register 0 are dropped so it stays hard-wired to zero.
      if (reg_write && wb_addr != 5'd0 && int'(wb_addr) < NREG) begin
        rf[wb_addr] <= wb_data;
      end
    end
  end

  assign mem.mem_addr  = i_or_d ? alu_out : pc;
  assign mem.mem_wdata = b_reg;
  assign op            = ir[31:26];
  assign pc_out        = pc;

endmodule

// File: doc/multi_datapath.md
MULTI_DATAPATH -- requirements
Module: multi_datapath

Interface
REQ-001 The block SHALL have the following parameters:
- XLEN, default 32, datapath width.
- NREG, default 32, number of architectural registers.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- i_or_d  in  1  memory address select: 0 = PC, 1 = ALUOut.
- ireg_enab  in  1  instruction-register load enable.
- pc_src  in  2  next-PC select.
- pc_write  in  1  unconditional PC write.
- branch  in  1  conditional PC write on ALU zero.
- mem_to_reg  in  1  write-back data select: 0 = ALUOut, 1 = MDR.
- reg_dst  in  1  write-back register select: 0 = rt, 1 = rd.
- reg_write  in  1  register-file write enable.
- alu_srcA  in  1  ALU A select: 0 = PC, 1 = A.
- alu_srcB  in  2  ALU B select.
- alu_op  in  2  ALU operation class.
- mem_rdata  in  XLEN  memory read data.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data, equal to register B.
- op  out  6  opcode, IR[31:26].
- pc_out  out  XLEN  current PC.
REQ-003 Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, named reset.

Function
REQ-004 The block SHALL hold these state registers: PC, IR, MDR, A, B, ALUOut, and a register file of NREG x XLEN.
REQ-005 mem_addr SHALL be combinational: PC when i_or_d=0, ALUOut when i_or_d=1.
REQ-006 IR SHALL load mem_rdata at the clock edge only when ireg_enab=1, and otherwise hold.
REQ-007 MDR SHALL load mem_rdata at every clock edge.
REQ-008 A and B SHALL load regfile[IR[25:21]] and regfile[IR[20:16]] respectively at every clock edge.
REQ-009 ALU operand A SHALL be PC when alu_srcA=0 and register A when alu_srcA=1.
REQ-010 ALU operand B SHALL be selected by alu_srcB:
- 00 = register B.
- 01 = constant 4.
- 10 = sign-extended IR[15:0].
- 11 = sign-extended IR[15:0] shifted left by 2.
REQ-011 The ALU operation SHALL be selected by alu_op:
- 00 = add.
- 01 = subtract (A-B).
- 10 = decode IR[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed set-less-than (result 1 or 0); any other funct gives result 0.
- 11 = result 0.
REQ-012 All arithmetic SHALL wrap modulo 2^XLEN, with no overflow flag or trap.
REQ-013 The internal signal zero SHALL be 1 exactly when the combinational ALU result equals 0.
REQ-014 ALUOut SHALL load the ALU result at every clock edge.
REQ-015 The next PC SHALL be selected by pc_src:
- 00 = ALU result.
- 01 = ALUOut.
- 10 = {PC[31:28], IR[25:0], 2'b00}.
- 11 = PC (hold).
REQ-016 PC SHALL update at the clock edge when (pc_write | (branch & zero)) = 1, and otherwise hold.
REQ-017 When reg_write=1, the register file SHALL write at the clock edge:
- Address: IR[15:11] when reg_dst=1, else IR[20:16].
- Data: MDR when mem_to_reg=1, else ALUOut.
REQ-018 Writes to register 0 SHALL be discarded, and register 0 SHALL always read 0.
REQ-019 Register-file reads SHALL be combinational. A read of a register being written in the same cycle SHALL return the old value (no bypass).
REQ-020 Control inputs in don't-care positions SHALL be accepted with any value, including X, without corrupting any register whose enable is 0.
REQ-021 op and pc_out SHALL be direct register outputs (IR[31:26] and PC), with no combinational path from any input.

Reset
REQ-022 On reset assertion, PC, IR, MDR, A, B, ALUOut and all register-file entries SHALL clear to 0 immediately, independent of clk.
REQ-023 While reset=1, no register SHALL change on clock edges. The first update SHALL occur on the first rising edge after deassertion.
REQ-024 Reset asserted mid-instruction SHALL abandon that instruction, leaving PC=0, op=0 and mem_addr=0 (with i_or_d=0).

Verification
REQ-025 Fetch: reset, mem_rdata=0x2008_0005, drive i_or_d=0, alu_srcA=0, alu_srcB=01, alu_op=00, pc_src=00, pc_write=1, ireg_enab=1 for one edge -> PC=4, IR=0x2008_0005, op=0x08.
REQ-026 ADDI: after REQ-025, run decode, then alu_srcA=1/alu_srcB=10/alu_op=00, then reg_write=1/reg_dst=0/mem_to_reg=0 -> $8 = 5; a later read of $8 into B = 5.
REQ-027 R-type sub/slt: $8=5, $9=7, IR=0x0109_502A (slt $10,$8,$9), alu_op=10, reg_dst=1 -> $10 = 1; with funct 0x22 -> $10 = 0xFFFF_FFFE.
REQ-028 BEQ: PC=8, $8=$9=3, IR offset=2:
- Decode with alu_srcB=11 gives ALUOut = 8+8 = 16.
- The branch cycle (alu_srcA=1, alu_srcB=00, alu_op=01, pc_src=01, branch=1) gives PC=16.
- Repeating with $9=4 leaves PC=8.
REQ-029 Jump and $0: IR=0x0800_0010, PC=0x1000_0004, pc_src=10, pc_write=1 -> PC=0x1000_0040. Separately, a write of 0xFFFF_FFFF to register 0 -> register 0 still reads 0.
REQ-030 Reset mid-operation: assert reset between clock edges during the LW memory-read phase (i_or_d=1) -> all registers 0 at once, no clock needed; after deassertion with i_or_d=0, mem_addr=0.
